// File: rtl/serial_sub_defs.sv
// ---------------------------------------------------------------------------
// serial_sub_defs
//
// Shared definitions for the bit-serial subtractor controller:
//   - state_t   : FSM state encodings (IDLE=0, RUN=1, DONE=2)
//   - WIDTH_MIN : smallest legal operand width
//   - WIDTH_MAX : largest legal operand width
//   - width_is_legal() : range check used at elaboration time
// ---------------------------------------------------------------------------
package serial_sub_defs;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_MIN = 1;
    localparam int WIDTH_MAX = 32;

    // True when the requested operand width is one the controller supports.
    function automatic bit width_is_legal(input int width);
        return (width >= WIDTH_MIN) && (width <= WIDTH_MAX);
    endfunction

endpackage

// File: rtl/serial_sub_bit.sv
// ---------------------------------------------------------------------------
// serial_sub_bit
//
// Combinational one-bit full subtractor computing a - b - bin.
// Built from two half-subtractor stages in series; the borrow out is the OR
// of the two stage borrows (at most one of them can be set at a time).
//
// Ports:
//   a    in   minuend bit
//   b    in   subtrahend bit
//   bin  in   borrow in from the previous (less significant) bit
//   d    out  difference bit
//   bout out  borrow out to the next (more significant) bit
// ---------------------------------------------------------------------------
module serial_sub_bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic hs1_d;
    logic hs1_b;
    logic hs2_b;

    // First half subtractor: a - b.
    // A borrow is needed only when a=0 and b=1.
    always_comb begin
        hs1_d = a ^ b;
        hs1_b = ~a & b;
    end

    // Second half subtractor takes the incoming borrow off the partial
    // difference, then both stage borrows are merged into the borrow out.
    always_comb begin
        d     = hs1_d ^ bin;
        hs2_b = ~hs1_d & bin;
        bout  = hs1_b | hs2_b;
    end

endmodule

// File: rtl/serial_sub_ctrl.sv
// ---------------------------------------------------------------------------
// serial_sub_ctrl
//
// Bit-serial WIDTH-bit subtractor controller. A start pulse in IDLE latches
// the operands, then one bit is subtracted per clock (LSB first) through a
// single serial_sub_bit cell, with the borrow carried between cycles in a
// register. The difference and final borrow are reported with a one-cycle
// done pulse and held until the next accepted start.
//
// Optional feature: define SERIAL_SUB_OVF_EN to add the signed overflow
// output ovf and the MSB capture logic behind it.
//
// Parameters:
//   WIDTH   operand/result width, 1..32 (default 8)
//
// Ports:
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset
//   start   in   operation request, accepted only in IDLE
//   a       in   minuend, sampled on the accepting edge
//   b       in   subtrahend, sampled on the accepting edge
//   busy    out  high while the subtraction is running
//   done    out  one-cycle pulse when diff/borrow are final
//   diff    out  a - b mod 2^WIDTH
//   borrow  out  final borrow (a < b unsigned)
//   ovf     out  signed overflow (only with SERIAL_SUB_OVF_EN)
// ---------------------------------------------------------------------------
module serial_sub_ctrl
    import serial_sub_defs::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    // Reject unsupported widths when the design is elaborated.
    if (!width_is_legal(WIDTH)) begin : g_bad_width
        $error("serial_sub_ctrl: WIDTH %0d outside %0d..%0d", WIDTH, WIDTH_MIN, WIDTH_MAX);
    end

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             last_step;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_shifted;
    logic [CNT_W-1:0] cnt;
    logic             bin_q;
    logic             d_bit;
    logic             bout;

    // The only arithmetic in the design: one full-subtract cell fed by the
    // LSBs of the operand shift registers and the stored borrow.
    serial_sub_bit u_bit (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (bin_q),
        .d    (d_bit),
        .bout (bout)
    );

    // New difference bits enter the result from the MSB side, so after WIDTH
    // steps the first (LSB) result bit has walked down to bit 0. A one-bit
    // result has nothing to shift, so it simply takes the new bit.
    if (WIDTH == 1) begin : g_res_w1
        assign res_shifted = d_bit;
    end else begin : g_res_wn
        assign res_shifted = {d_bit, res[WIDTH-1:1]};
    end

    // State register. Reset forces IDLE immediately, which also drops busy
    // and done because they are decoded straight from the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and status decode. start only matters in IDLE; in RUN and
    // DONE it is ignored rather than queued. DONE always lasts one cycle so
    // done is a single-cycle pulse.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        last_step = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == LAST_BIT) begin
                    last_step = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Serial datapath. The accepting edge loads the operands and clears the
    // borrow, counter and result; every RUN edge consumes one operand bit.
    // Outside those two cases every register holds, which is what keeps
    // diff and borrow stable through DONE and the following IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            res   <= '0;
            cnt   <= '0;
            bin_q <= 1'b0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b;
            res   <= '0;
            cnt   <= '0;
            bin_q <= 1'b0;
        end else if (state == RUN) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            res   <= res_shifted;
            cnt   <= cnt + CNT_W'(1);
            bin_q <= bout;
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    // Signed overflow happens when the operand signs differ and the result
    // sign differs from the minuend. On the last step the shift registers
    // present the operand MSBs and the cell produces the result MSB, so the
    // flag is captured there and then held like diff.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (accept) begin
            ovf <= 1'b0;
        end else if (last_step) begin
            ovf <= (a_sh[0] ^ b_sh[0]) & (a_sh[0] ^ d_bit);
        end
    end
`endif

    assign diff   = res;
    assign borrow = bin_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_sub_ctrl
//
// Self-checking bench for serial_sub_ctrl. Two instances share clock and
// reset: one with WIDTH=8 and one with WIDTH=1. Expected results are pushed
// to a per-instance queue when an operation is launched and popped when the
// instance raises done. Build with SERIAL_SUB_OVF_EN defined to also check
// the signed overflow output.
// ---------------------------------------------------------------------------
module tb_serial_sub_ctrl;

    typedef struct packed {
        logic [7:0] diff;
        logic       borrow;
        logic       ovf;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] diff;
        logic       borrow;
        logic       ovf;
    } vec_t;

    localparam int NVEC = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       busy8;
    logic       done8;
    logic [7:0] diff8;
    logic       borrow8;

    logic       start1 = 1'b0;
    logic [0:0] a1 = '0;
    logic [0:0] b1 = '0;
    logic       busy1;
    logic       done1;
    logic [0:0] diff1;
    logic       borrow1;

`ifdef SERIAL_SUB_OVF_EN
    logic       ovf8;
    logic       ovf1;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t q8[$];
    exp_t q1[$];
    vec_t vecs[NVEC];

    serial_sub_ctrl #(.WIDTH(8)) dut8 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start8),
        .a      (a8),
        .b      (b8),
        .busy   (busy8),
        .done   (done8),
        .diff   (diff8),
        .borrow (borrow8)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf    (ovf8)
`endif
    );

    serial_sub_ctrl #(.WIDTH(1)) dut1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start1),
        .a      (a1),
        .b      (b1),
        .busy   (busy1),
        .done   (done1),
        .diff   (diff1),
        .borrow (borrow1)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf    (ovf1)
`endif
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Guard against a hung run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic getDone(input bit sel);
        return sel ? done1 : done8;
    endfunction

    function automatic logic getBusy(input bit sel);
        return sel ? busy1 : busy8;
    endfunction

    function automatic logic [7:0] getDiff(input bit sel);
        return sel ? {7'd0, diff1} : diff8;
    endfunction

    function automatic logic getBorrow(input bit sel);
        return sel ? borrow1 : borrow8;
    endfunction

`ifdef SERIAL_SUB_OVF_EN
    function automatic logic getOvf(input bit sel);
        return sel ? ovf1 : ovf8;
    endfunction
`endif

    task automatic setInputs(input bit sel, input logic s, input logic [7:0] a, input logic [7:0] b);
        if (sel) begin
            start1 = s;
            a1     = a[0];
            b1     = b[0];
        end else begin
            start8 = s;
            a8     = a;
            b8     = b;
        end
    endtask

    // Launch one operation on the selected instance, wait (bounded) for done
    // and compare against the scoreboard entry plus the latency rules.
    task automatic applyStimulus(input bit sel, input logic [7:0] a, input logic [7:0] b,
                                 input exp_t e, input string tag);
        int   lat;
        int   busyCnt;
        int   width;
        bit   seen;
        exp_t want;
        width = sel ? 1 : 8;
        @(negedge clk);
        setInputs(sel, 1'b1, a, b);
        if (sel) q1.push_back(e);
        else q8.push_back(e);
        @(posedge clk);
        @(negedge clk);
        setInputs(sel, 1'b0, 8'($urandom), 8'($urandom));
        lat     = 1;
        busyCnt = 0;
        seen    = 0;
        while (!seen && lat <= 40) begin
            if (getDone(sel) === 1'b1) begin
                seen = 1;
            end else begin
                if (getBusy(sel) === 1'b1) busyCnt++;
                @(negedge clk);
                lat++;
            end
        end
        checkOutput({tag, "_done_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            checkOutput({tag, "_sb_nonempty"}, sel ? q1.size() : q8.size(), 32'd1);
            want = sel ? q1.pop_front() : q8.pop_front();
            checkOutput({tag, "_diff"}, 32'(getDiff(sel)), 32'(want.diff));
            checkOutput({tag, "_borrow"}, 32'(getBorrow(sel)), 32'(want.borrow));
`ifdef SERIAL_SUB_OVF_EN
            checkOutput({tag, "_ovf"}, 32'(getOvf(sel)), 32'(want.ovf));
`endif
            checkOutput({tag, "_latency"}, 32'(lat), 32'(width + 1));
            checkOutput({tag, "_busy_cycles"}, 32'(busyCnt), 32'(width));
            checkOutput({tag, "_busy_at_done"}, 32'(getBusy(sel)), 32'd0);
            @(negedge clk);
            checkOutput({tag, "_done_one_cycle"}, 32'(getDone(sel)), 32'd0);
            checkOutput({tag, "_diff_hold"}, 32'(getDiff(sel)), 32'(want.diff));
            checkOutput({tag, "_borrow_hold"}, 32'(getBorrow(sel)), 32'(want.borrow));
        end else begin
            if (sel) q1.delete();
            else q8.delete();
        end
    endtask

    initial begin
        int   lat;
        int   nDone;
        int   lastCyc;
        bit   seen;
        bit   extra;
        exp_t e;

        vecs[0] = '{8'd5,  8'd3,  8'h02, 1'b0, 1'b0};
        vecs[1] = '{8'd3,  8'd5,  8'hFE, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
        vecs[3] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
        vecs[4] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
        vecs[5] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
        vecs[6] = '{8'hAA, 8'h55, 8'h55, 1'b0, 1'b1};
        vecs[7] = '{8'h55, 8'hAA, 8'hAB, 1'b1, 1'b1};
        vecs[8] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[9] = '{8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0};

        // Reset state on both instances.
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_busy8", 32'(busy8), 32'd0);
        checkOutput("rst_done8", 32'(done8), 32'd0);
        checkOutput("rst_diff8", 32'(diff8), 32'd0);
        checkOutput("rst_borrow8", 32'(borrow8), 32'd0);
        checkOutput("rst_busy1", 32'(busy1), 32'd0);
        checkOutput("rst_done1", 32'(done1), 32'd0);
        checkOutput("rst_diff1", 32'(diff1), 32'd0);
        checkOutput("rst_borrow1", 32'(borrow1), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        checkOutput("rst_ovf8", 32'(ovf8), 32'd0);
        checkOutput("rst_ovf1", 32'(ovf1), 32'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven operations on the 8-bit instance.
        for (int i = 0; i < NVEC; i++) begin
            e = '{vecs[i].diff, vecs[i].borrow, vecs[i].ovf};
            applyStimulus(1'b0, vecs[i].a, vecs[i].b, e, $sformatf("vec%0d", i));
        end

        // start pulses during RUN and during DONE must be ignored.
        $display("[TB] start ignored in RUN and DONE");
        @(negedge clk);
        start8 = 1'b1; a8 = 8'd5; b8 = 8'd3;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        start8 = 1'b1; a8 = 8'h10; b8 = 8'h20;
        @(negedge clk);
        start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
        lat  = 0;
        seen = 0;
        while (!seen && lat < 40) begin
            if (done8 === 1'b1) seen = 1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        checkOutput("ign_done_seen", 32'(seen), 32'd1);
        checkOutput("ign_run_diff", 32'(diff8), 32'h02);
        checkOutput("ign_run_borrow", 32'(borrow8), 32'd0);
        start8 = 1'b1; a8 = 8'hF0; b8 = 8'h0F;
        @(negedge clk);
        start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
        extra = 0;
        repeat (14) begin
            if (done8 !== 1'b0 || busy8 !== 1'b0) extra = 1;
            @(negedge clk);
        end
        checkOutput("ign_done_no_restart", 32'(extra), 32'd0);
        checkOutput("ign_diff_still", 32'(diff8), 32'h02);
        applyStimulus(1'b0, 8'hF0, 8'h0F, '{8'hE1, 1'b0, 1'b0}, "fresh_start");

        // Asynchronous reset three edges into RUN.
        $display("[TB] reset during RUN");
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h12; b8 = 8'h34;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checkOutput("midrun_busy", 32'(busy8), 32'd1);
        checkOutput("midrun_diff", 32'(diff8), 32'hC0);
        checkOutput("midrun_borrow", 32'(borrow8), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("arst_busy", 32'(busy8), 32'd0);
        checkOutput("arst_done", 32'(done8), 32'd0);
        checkOutput("arst_diff", 32'(diff8), 32'd0);
        checkOutput("arst_borrow", 32'(borrow8), 32'd0);
        extra = 0;
        repeat (10) begin
            @(negedge clk);
            if (done8 !== 1'b0 || busy8 !== 1'b0) extra = 1;
            if (extra) rst_n = 1'b1;
            if (extra) rst_n = 1'b0;
        end
        checkOutput("arst_no_done", 32'(extra), 32'd0);
        rst_n = 1'b1;
        applyStimulus(1'b0, 8'hFF, 8'hFF, '{8'h00, 1'b0, 1'b0}, "after_rst");

        // Single-bit instance.
        applyStimulus(1'b1, 8'd0, 8'd1, '{8'h01, 1'b1, 1'b1}, "w1_0m1");
        applyStimulus(1'b1, 8'd1, 8'd1, '{8'h00, 1'b0, 1'b0}, "w1_1m1");

        // start held high: one result every WIDTH+2 = 3 cycles.
        $display("[TB] WIDTH=1 back-to-back");
        @(negedge clk);
        start1 = 1'b1; a1 = 1'b1; b1 = 1'b0;
        nDone   = 0;
        lastCyc = -1;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            if (done1 === 1'b1) begin
                if (lastCyc >= 0) checkOutput($sformatf("held_spacing%0d", nDone), 32'(c - lastCyc), 32'd3);
                else checkOutput("held_first_done", 32'(c), 32'd2);
                checkOutput($sformatf("held_diff%0d", nDone), 32'(diff1), 32'd1);
                checkOutput($sformatf("held_borrow%0d", nDone), 32'(borrow1), 32'd0);
                lastCyc = c;
                nDone++;
            end
        end
        checkOutput("held_count", 32'(nDone), 32'd5);
        start1 = 1'b0;
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
